// File: rtl/clock_set_ctrl.sv
// Time-setting controller: walks RUN -> SET_HOUR -> SET_MIN on key pulses, edits hour/minute,
// blinks the field being edited and commits with a one-cycle load strobe. Idle timeout abandons the edit.
module clock_set_ctrl #(
    parameter int TIMEOUT_SEC = 30,
    parameter int BLINK_HALF  = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_short,
    input  logic       key_long,
    input  logic       tick_sec,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    output logic [4:0] set_hour,
    output logic [5:0] set_min,
    output logic       load,
    output logic [1:0] set_mode,
    output logic       blink
);

    localparam logic [1:0] S_RUN  = 2'b00;
    localparam logic [1:0] S_HOUR = 2'b01;
    localparam logic [1:0] S_MIN  = 2'b10;

    localparam logic [7:0]  IDLE_LAST  = 8'(TIMEOUT_SEC - 1);
    localparam logic [25:0] BLINK_LAST = 26'(BLINK_HALF - 1);

    logic [1:0]  mode, nxt_mode;
    logic [7:0]  idle_cnt;
    logic [25:0] blink_cnt;
    logic        capture, inc_hour, inc_min, commit, restart_blink;
    logic        key_any, tick_to;

    assign key_any = key_short | key_long;
    // The tick that would bring the idle count up to TIMEOUT_SEC.
    assign tick_to = tick_sec && (idle_cnt == IDLE_LAST);

    // key_long outranks key_short, and any key outranks a timeout in the same cycle.
    always_comb begin
        nxt_mode      = mode;
        capture       = 1'b0;
        inc_hour      = 1'b0;
        inc_min       = 1'b0;
        commit        = 1'b0;
        restart_blink = 1'b0;
        case (mode)
            S_RUN: begin
                if (key_long) begin
                    nxt_mode      = S_HOUR;
                    capture       = 1'b1;
                    restart_blink = 1'b1;
                end
            end
            S_HOUR: begin
                if (key_long) begin
                    nxt_mode      = S_MIN;
                    restart_blink = 1'b1;
                end else if (key_short) begin
                    inc_hour      = 1'b1;
                    restart_blink = 1'b1;
                end else if (tick_to) begin
                    nxt_mode = S_RUN;
                end
            end
            S_MIN: begin
                if (key_long) begin
                    nxt_mode = S_RUN;
                    commit   = 1'b1;
                end else if (key_short) begin
                    inc_min       = 1'b1;
                    restart_blink = 1'b1;
                end else if (tick_to) begin
                    nxt_mode = S_RUN;
                end
            end
            default: nxt_mode = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode      <= S_RUN;
            set_hour  <= 5'd0;
            set_min   <= 6'd0;
            load      <= 1'b0;
            idle_cnt  <= 8'd0;
            blink_cnt <= 26'd0;
            blink     <= 1'b0;
        end else begin
            mode <= nxt_mode;
            load <= commit;

            if (capture) begin
                set_hour <= (cur_hour > 5'd23) ? 5'd0 : cur_hour;
                set_min  <= (cur_min  > 6'd59) ? 6'd0 : cur_min;
            end else if (inc_hour) begin
                set_hour <= (set_hour == 5'd23) ? 5'd0 : set_hour + 5'd1;
            end else if (inc_min) begin
                set_min  <= (set_min == 6'd59) ? 6'd0 : set_min + 6'd1;
            end

            if (mode == S_RUN || nxt_mode == S_RUN || key_any)
                idle_cnt <= 8'd0;
            else if (tick_sec)
                idle_cnt <= idle_cnt + 8'd1;

            if (nxt_mode == S_RUN) begin
                blink     <= 1'b0;
                blink_cnt <= 26'd0;
            end else if (restart_blink) begin
                blink     <= 1'b1;
                blink_cnt <= 26'd0;
            end else if (blink_cnt == BLINK_LAST) begin
                blink     <= ~blink;
                blink_cnt <= 26'd0;
            end else begin
                blink_cnt <= blink_cnt + 26'd1;
            end
        end
    end

    assign set_mode = mode;

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Time-setting controller for the digital clock. It consumes the single-cycle short and long key-press pulses produced by the key press classifier and sequences the time counter through run, set-hour and set-minute modes. It holds the edited hour/minute values, drives a display blink enable for the field being edited, and commits the edited time to the time counter with a one-cycle load strobe. An inactivity timeout abandons an edit without committing it.

## Interface

- TIMEOUT_SEC, default 30: number of `tick_sec` pulses without a key event before a set mode is abandoned (range 1..255).
- BLINK_HALF, default 25_000_000: clock cycles per blink half-period (range 1..2^26−1).

- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- key_short  in  1  one-cycle pulse for a short key press.
- key_long  in  1  one-cycle pulse for a long key press.
- tick_sec  in  1  one-cycle pulse once per second, from the time base.
- cur_hour  in  5  current hour from the time counter (0..23).
- cur_min  in  6  current minute from the time counter (0..59).
- set_hour  out  5  edited hour value.
- set_min  out  6  edited minute value.
- load  out  1  one-cycle commit strobe; the time counter loads `set_hour`/`set_min` and clears seconds.
- set_mode  out  2  current mode: 00 = RUN, 01 = SET_HOUR, 10 = SET_MIN (11 never occurs).
- blink  out  1  1 = edited field visible, 0 = blanked; always 0 in RUN.

## Operation

- **States:** RUN, SET_HOUR, SET_MIN. `set_mode` is the registered state encoding.
- **RUN**
  - `key_long` → capture `cur_hour`/`cur_min` into `set_hour`/`set_min`, then go to SET_HOUR.
  - Out-of-range captures are clamped to 0: hour > 23 → 0, minute > 59 → 0.
  - `key_short` is ignored.
- **SET_HOUR**
  - `key_short` → `set_hour` = 23 ? 0 : `set_hour` + 1.
  - `key_long` → go to SET_MIN.
- **SET_MIN**
  - `key_short` → `set_min` = 59 ? 0 : `set_min` + 1.
  - `key_long` → assert `load` for one cycle and go to RUN.
- **Timeout**
  - An 8-bit idle counter runs only in the set states. It clears on entry to any set state and on any key pulse, and increments on `tick_sec`.
  - When it reaches TIMEOUT_SEC, go to RUN with no `load`; `set_hour`/`set_min` keep their edited values.
- **Simultaneous events**
  - `key_short` and `key_long` in the same cycle: `key_long` wins, `key_short` is dropped.
  - Key pulse and timeout-reaching `tick_sec` in the same cycle: the key wins, the counter clears, and no timeout occurs.
- **Blink**
  - A cycle counter runs in the set states and toggles `blink` every BLINK_HALF cycles.
  - `blink` is forced to 1 and the counter cleared on entry to a set state and on every accepted `key_short`, so the edited value is visible immediately.
  - In RUN, `blink` = 0 and the counter is held at 0.
- **Hold behaviour:** `set_hour`/`set_min` hold their values in RUN and change only on capture or increment.

## Timing

- **Reset values:** `set_mode` = 00 (RUN), `set_hour` = 0, `set_min` = 0, `load` = 0, `blink` = 0, idle and blink counters = 0.
- **Reset mid-edit:** returns to RUN next cycle with no `load`, including when reset coincides with `key_long` in SET_MIN.
- **Latency:** all outputs are registered, one cycle after the triggering input edge.
  - Capture: `key_long` in RUN at cycle n → `set_mode` = 01, captured values and `blink` = 1 valid at n+1.
  - Increment: visible at n+1.
- **Commit:** `key_long` in SET_MIN at cycle n → `load` = 1 and `set_mode` = 00 at n+1; `load` = 0 at n+2.
  - `set_hour`/`set_min` are stable from n+1 onward and are not modified in the commit cycle.
- **Timeout:** the TIMEOUT_SEC-th qualifying `tick_sec` at cycle n → `set_mode` = 00 at n+1, `load` stays 0.
- **Blink period:** toggles at exactly BLINK_HALF-cycle intervals after the last entry or `key_short`.

## Test plan

- **Reset:** hold `rst` = 1 for 3 cycles while driving `key_long` → all outputs at reset values; after release, `set_mode` = 00.
- **Capture with clamp:** `cur_hour` = 14, `cur_min` = 37, pulse `key_long` → next cycle `set_mode` = 01, `set_hour` = 14, `set_min` = 37, `blink` = 1. Repeat with `cur_hour` = 30 → `set_hour` = 0.
- **Full edit and commit:**
  - From `set_hour` = 22, apply 3 `key_short` → 23, 0, 1.
  - `key_long` → `set_mode` = 10.
  - From `set_min` = 58, apply 2 `key_short` → 59, 0.
  - `key_long` → exactly one `load` cycle with `set_hour` = 1, `set_min` = 0, `set_mode` = 00.
- **Simultaneous keys:** `key_short` and `key_long` together in SET_HOUR with `set_hour` = 5 → `set_mode` = 10, `set_hour` stays 5.
- **Timeout (TIMEOUT_SEC = 3):**
  - In SET_MIN, pulse 3 `tick_sec` with no keys → `set_mode` = 00, no `load`.
  - Repeat with `key_short` coincident with the 3rd tick → stays in SET_MIN, and 3 further ticks are needed.
- **Blink (BLINK_HALF = 4):**
  - In SET_HOUR, `blink` pattern 1111 0000 1111.
  - `key_short` mid-low phase → `blink` = 1 next cycle, and the next toggle occurs 4 cycles later.
  - In RUN, `blink` stays 0.
